xsim_dma_burst_arbiter: RTL and testbench
=========================================

Name: xsim_dma_burst_arbiter

Overview:
- Shares the single 32-bit simulated DMA port (readrequest/readresponse/write32) among NUM_CLIENTS requesters.
- Read side: round-robin arbitration of multi-beat read bursts; the arbiter expands each burst into per-word read requests and routes responses back to the owning client.
- Write side: independent round-robin arbitration of single-beat writes, one per cycle.
- Sits between DMA client engines and the DPI-backed sim DMA endpoint.

Parameters:
- NUM_CLIENTS, 4, number of requesters (2..8).
- BEATS_W, 8, width of the burst length field; maximum burst is 2^BEATS_W words.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- rd_req_valid  in  NUM_CLIENTS  per-client read burst request.
- rd_req_ready  out  NUM_CLIENTS  one-hot acceptance pulse.
- rd_req_handle  in  32*NUM_CLIENTS  memory handle, client i at [32i+31:32i].
- rd_req_addr  in  32*NUM_CLIENTS  byte address of the first word.
- rd_req_beats  in  BEATS_W*NUM_CLIENTS  beat count minus one.
- rd_data_valid  out  NUM_CLIENTS  one-hot: response word available for that client.
- rd_data_ready  in  NUM_CLIENTS  client consumes the word.
- rd_data  out  32  response word (shared).
- rd_data_last  out  1  marks the final word of the burst.
- wr_valid  in  NUM_CLIENTS  per-client write request.
- wr_ready  out  NUM_CLIENTS  one-hot acceptance.
- wr_handle, wr_addr, wr_data  in  32*NUM_CLIENTS each  write fields.
- wr_byteenable  in  4*NUM_CLIENTS  byte enables.
- dma_rdy_readrequest  in  1  endpoint can accept a read.
- dma_en_readrequest  out  1  issue read.
- dma_readrequest_addr, dma_readrequest_handle  out  32  read fields.
- dma_rdy_readresponse  in  1  endpoint holds a response.
- dma_en_readresponse  out  1  consume the response.
- dma_readresponse_data  in  32  response data.
- dma_en_write32  out  1  write strobe.
- dma_write32_addr, dma_write32_handle, dma_write32_data  out  32  write fields.
- dma_write32_byteenable  out  4  write byte enables.

Behaviour:
- Reset values:
  - Read FSM = IDLE.
  - Both RR pointers = NUM_CLIENTS-1, so client 0 wins first.
  - Counters = 0.
  - All en/ready/valid outputs = 0.
  - Address/handle/data output registers = 0.
- Reset mid-burst abandons the burst with no further responses. The endpoint shares RST.
- Read FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - If any rd_req_valid, grant the RR winner: the first requester searching from pointer+1 upward, modulo NUM_CLIENTS.
  - rd_req_ready[winner]=1 for that one cycle.
  - Latch owner, handle, addr, and beats+1 into a BEATS_W+1 bit total.
  - Clear the issued and returned counters, set the pointer to the winner, go to ISSUE.
- ISSUE:
  - dma_en_readrequest = dma_rdy_readrequest (combinational).
  - On each issue: addr += 4 (wraps mod 2^32), issued++.
  - When the final beat issues, go to DRAIN.
- Response path, active in both ISSUE and DRAIN:
  - rd_data_valid[owner] = dma_rdy_readresponse.
  - rd_data = dma_readresponse_data.
  - dma_en_readresponse = dma_rdy_readresponse && rd_data_ready[owner]. Each consume increments returned.
  - rd_data_last = valid && returned == total-1.
- DRAIN: on the last consume, go to IDLE. A new grant is possible the following cycle.
- Simultaneous issue and consume in one cycle is legal; both counters update.
- Read latency: the first dma_en_readrequest occurs 1 cycle after the grant, if the endpoint is ready.
- No read is ever issued outside ISSUE. Issue never exceeds total.
- Write side, independent of reads:
  - Each cycle, RR-select among wr_valid; wr_ready[winner]=1 (combinational, no backpressure).
  - Register the winner's fields to the dma_write32_* outputs with dma_en_write32=1 the next cycle, otherwise 0.
  - Pointer advances to the winner.
  - Throughput: 1 write per cycle.
- No read/write ordering is enforced across clients or between the read and write paths. Clients order their own traffic.

Decomposition:
- Package xsim_dma_arb_pkg: read FSM state enum, DMA_WORD_BYTES=4, default NUM_CLIENTS/BEATS_W, beat-count helper width.
- Sub-module xsim_rr_arbiter (parameter N; inputs req, ptr; outputs one-hot grant, grant index, any).
- xsim_rr_arbiter is combinational and instantiated twice (read and write). Pointer registers live in the parent.

Test Plan:
- Client 0 issues addr=0x100, beats=0, endpoint always ready, rd_data_ready=1:
  - Expect one readrequest at 0x100 one cycle after rd_req_ready[0].
  - Expect rd_data_valid[0] with rd_data_last=1, then FSM back to IDLE.
- Client 2 issues a 4-beat burst at 0x200 with rd_data_ready toggled 1,0,1,0:
  - Expect requests at 0x200/0x204/0x208/0x20C in order.
  - Expect no request issued while the endpoint holds an unconsumed response.
  - Expect last asserted only on the 4th word.
- Clients 0,1,3 request simultaneously from reset:
  - Expect grants in order 0,1,3, then 0 again if it re-requests.
  - Expect no overlap between bursts.
- Burst at addr=0xFFFFFFF8, beats=3:
  - Expect addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- All 4 clients assert wr_valid continuously with distinct data:
  - Expect wr_ready rotating 0,1,2,3,0.
  - Expect dma_en_write32 every cycle, carrying the matching client's fields with 1-cycle latency.
- RST asserted during the 3rd beat of an 8-beat burst:
  - Expect all outputs 0 next cycle and FSM IDLE.
  - Expect a new request after reset to be granted to client 0 first.

Source files
------------

// File: rtl/xsim_dma_arb_pkg.sv
// Shared types and constants for the sim DMA burst arbiter.
//   rd_state_t          : read burst FSM states
//   DMA_WORD_BYTES      : byte stride between consecutive read beats
//   DEFAULT_NUM_CLIENTS : default requester count
//   DEFAULT_BEATS_W     : default burst-length field width
//   beat_cnt_w()        : width of a beat counter able to hold 2^beats_w
package xsim_dma_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  localparam int unsigned DMA_WORD_BYTES      = 4;
  localparam int unsigned DEFAULT_NUM_CLIENTS = 4;
  localparam int unsigned DEFAULT_BEATS_W     = 8;

  // Beat field holds count-1, so the full count needs one more bit.
  function automatic int unsigned beat_cnt_w(input int unsigned beats_w);
    return beats_w + 1;
  endfunction

endpackage

// File: rtl/xsim_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index of the previous winner; search starts at ptr+1
//   grant     : one-hot grant (zero when no request)
//   grant_idx : index of the granted requester
//   any       : at least one request present
module xsim_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  // First requester found walking upward from ptr+1, modulo N.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!any && req[IW'(idx)]) begin
        any       = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/xsim_dma_burst_arbiter.sv
// Shares one 32-bit sim DMA port among NUM_CLIENTS requesters.
// Reads: round-robin granted bursts, expanded into per-word read requests,
// responses routed back to the owning client. Writes: independent
// round-robin, one single-beat write per cycle, registered to the port.
//   CLK, RST                : clock, synchronous active-high reset
//   rd_req_*                : per-client read burst request (valid/ready)
//   rd_data_*               : shared read response path, per-client valid/ready
//   wr_*                    : per-client single-beat write request
//   dma_*readrequest*       : read request port to the endpoint
//   dma_*readresponse*      : read response port from the endpoint
//   dma_*write32*           : write port to the endpoint
module xsim_dma_burst_arbiter
  import xsim_dma_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = DEFAULT_NUM_CLIENTS,
  parameter int unsigned BEATS_W     = DEFAULT_BEATS_W
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_CLIENTS-1:0]         rd_req_valid,
  output logic [NUM_CLIENTS-1:0]         rd_req_ready,
  input  logic [32*NUM_CLIENTS-1:0]      rd_req_handle,
  input  logic [32*NUM_CLIENTS-1:0]      rd_req_addr,
  input  logic [BEATS_W*NUM_CLIENTS-1:0] rd_req_beats,
  output logic [NUM_CLIENTS-1:0]         rd_data_valid,
  input  logic [NUM_CLIENTS-1:0]         rd_data_ready,
  output logic [31:0]                    rd_data,
  output logic                           rd_data_last,
  input  logic [NUM_CLIENTS-1:0]         wr_valid,
  output logic [NUM_CLIENTS-1:0]         wr_ready,
  input  logic [32*NUM_CLIENTS-1:0]      wr_handle,
  input  logic [32*NUM_CLIENTS-1:0]      wr_addr,
  input  logic [32*NUM_CLIENTS-1:0]      wr_data,
  input  logic [4*NUM_CLIENTS-1:0]       wr_byteenable,
  input  logic                           dma_rdy_readrequest,
  output logic                           dma_en_readrequest,
  output logic [31:0]                    dma_readrequest_addr,
  output logic [31:0]                    dma_readrequest_handle,
  input  logic                           dma_rdy_readresponse,
  output logic                           dma_en_readresponse,
  input  logic [31:0]                    dma_readresponse_data,
  output logic                           dma_en_write32,
  output logic [31:0]                    dma_write32_addr,
  output logic [31:0]                    dma_write32_handle,
  output logic [31:0]                    dma_write32_data,
  output logic [3:0]                     dma_write32_byteenable
);

  localparam int unsigned CW = $clog2(NUM_CLIENTS);
  localparam int unsigned TW = beat_cnt_w(BEATS_W);

  rd_state_t               rd_state;
  logic [CW-1:0]           rd_ptr;
  logic [CW-1:0]           rd_owner;
  logic [31:0]             rd_addr_q;
  logic [31:0]             rd_handle_q;
  logic [TW-1:0]           rd_total;
  logic [TW-1:0]           rd_issued;
  logic [TW-1:0]           rd_returned;
  logic [TW-1:0]           rd_last_idx;
  logic [CW-1:0]           wr_ptr;

  logic [NUM_CLIENTS-1:0]  rd_gnt;
  logic [CW-1:0]           rd_gnt_idx;
  logic                    rd_any;
  logic [NUM_CLIENTS-1:0]  wr_gnt;
  logic [CW-1:0]           wr_gnt_idx;
  logic                    wr_any;

  logic [31:0]             sel_rd_handle;
  logic [31:0]             sel_rd_addr;
  logic [BEATS_W-1:0]      sel_rd_beats;
  logic [31:0]             sel_wr_handle;
  logic [31:0]             sel_wr_addr;
  logic [31:0]             sel_wr_data;
  logic [3:0]              sel_wr_be;

  logic                    rd_active;
  logic                    rsp_valid;

  xsim_rr_arbiter #(.N(NUM_CLIENTS)) u_rd_arb (
    .req       (rd_req_valid),
    .ptr       (rd_ptr),
    .grant     (rd_gnt),
    .grant_idx (rd_gnt_idx),
    .any       (rd_any)
  );

  xsim_rr_arbiter #(.N(NUM_CLIENTS)) u_wr_arb (
    .req       (wr_valid),
    .ptr       (wr_ptr),
    .grant     (wr_gnt),
    .grant_idx (wr_gnt_idx),
    .any       (wr_any)
  );

  // Field muxes for the current read and write winners.
  always_comb begin
    sel_rd_handle = '0;
    sel_rd_addr   = '0;
    sel_rd_beats  = '0;
    sel_wr_handle = '0;
    sel_wr_addr   = '0;
    sel_wr_data   = '0;
    sel_wr_be     = '0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      if (rd_gnt_idx == CW'(i)) begin
        sel_rd_handle = rd_req_handle[32*i +: 32];
        sel_rd_addr   = rd_req_addr[32*i +: 32];
        sel_rd_beats  = rd_req_beats[BEATS_W*i +: BEATS_W];
      end
      if (wr_gnt_idx == CW'(i)) begin
        sel_wr_handle = wr_handle[32*i +: 32];
        sel_wr_addr   = wr_addr[32*i +: 32];
        sel_wr_data   = wr_data[32*i +: 32];
        sel_wr_be     = wr_byteenable[4*i +: 4];
      end
    end
  end

  // Handshake outputs are gated during reset so nothing is accepted and then dropped.
  assign rd_active           = (rd_state == RD_ISSUE) || (rd_state == RD_DRAIN);
  assign rd_req_ready        = (!RST && rd_state == RD_IDLE && rd_any) ? rd_gnt : '0;
  assign dma_en_readrequest  = !RST && (rd_state == RD_ISSUE) && dma_rdy_readrequest;
  assign rsp_valid           = !RST && rd_active && dma_rdy_readresponse;
  assign rd_data_valid       = rsp_valid ? (NUM_CLIENTS'(1) << rd_owner) : '0;
  assign dma_en_readresponse = rsp_valid && rd_data_ready[rd_owner];
  assign rd_data             = dma_readresponse_data;
  assign rd_last_idx         = rd_total - TW'(1);
  assign rd_data_last        = rsp_valid && (rd_returned == rd_last_idx);
  assign dma_readrequest_addr   = rd_addr_q;
  assign dma_readrequest_handle = rd_handle_q;
  assign wr_ready            = (!RST && wr_any) ? wr_gnt : '0;

  // Read burst FSM: grant in IDLE, issue beats in ISSUE, wait for tail responses in DRAIN.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_state    <= RD_IDLE;
      rd_ptr      <= CW'(NUM_CLIENTS - 1);
      rd_owner    <= '0;
      rd_addr_q   <= '0;
      rd_handle_q <= '0;
      rd_total    <= '0;
      rd_issued   <= '0;
      rd_returned <= '0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_any) begin
            rd_owner    <= rd_gnt_idx;
            rd_ptr      <= rd_gnt_idx;
            rd_handle_q <= sel_rd_handle;
            rd_addr_q   <= sel_rd_addr;
            rd_total    <= TW'(sel_rd_beats) + TW'(1);
            rd_issued   <= '0;
            rd_returned <= '0;
            rd_state    <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (dma_en_readrequest) begin
            rd_addr_q <= rd_addr_q + 32'(DMA_WORD_BYTES);
            rd_issued <= rd_issued + TW'(1);
            if (rd_issued == rd_last_idx) rd_state <= RD_DRAIN;
          end
          // The final response cannot arrive before the final issue, so no exit here.
          if (dma_en_readresponse) rd_returned <= rd_returned + TW'(1);
        end
        RD_DRAIN: begin
          if (dma_en_readresponse) begin
            rd_returned <= rd_returned + TW'(1);
            if (rd_returned == rd_last_idx) rd_state <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write path: winner's fields appear on the port one cycle after wr_ready.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr                 <= CW'(NUM_CLIENTS - 1);
      dma_en_write32         <= 1'b0;
      dma_write32_addr       <= '0;
      dma_write32_handle     <= '0;
      dma_write32_data       <= '0;
      dma_write32_byteenable <= '0;
    end else begin
      dma_en_write32 <= wr_any;
      if (wr_any) begin
        wr_ptr                 <= wr_gnt_idx;
        dma_write32_addr       <= sel_wr_addr;
        dma_write32_handle     <= sel_wr_handle;
        dma_write32_data       <= sel_wr_data;
        dma_write32_byteenable <= sel_wr_be;
      end
    end
  end

endmodule

// File: tb/tb_xsim_dma_burst_arbiter.sv
// Bench for xsim_dma_burst_arbiter: table-driven read bursts and write
// rotation plus hand sequences for multi-client arbitration and reset.
// A single-entry endpoint model answers each read with addr^handle^const.
module tb_xsim_dma_burst_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned BW = 8;

  logic              CLK;
  logic              RST;
  logic [N-1:0]      rd_req_valid;
  logic [N-1:0]      rd_req_ready;
  logic [32*N-1:0]   rd_req_handle;
  logic [32*N-1:0]   rd_req_addr;
  logic [BW*N-1:0]   rd_req_beats;
  logic [N-1:0]      rd_data_valid;
  logic [N-1:0]      rd_data_ready;
  logic [31:0]       rd_data;
  logic              rd_data_last;
  logic [N-1:0]      wr_valid;
  logic [N-1:0]      wr_ready;
  logic [32*N-1:0]   wr_handle;
  logic [32*N-1:0]   wr_addr;
  logic [32*N-1:0]   wr_data;
  logic [4*N-1:0]    wr_byteenable;
  logic              dma_rdy_readrequest;
  logic              dma_en_readrequest;
  logic [31:0]       dma_readrequest_addr;
  logic [31:0]       dma_readrequest_handle;
  logic              dma_rdy_readresponse;
  logic              dma_en_readresponse;
  logic [31:0]       dma_readresponse_data;
  logic              dma_en_write32;
  logic [31:0]       dma_write32_addr;
  logic [31:0]       dma_write32_handle;
  logic [31:0]       dma_write32_data;
  logic [3:0]        dma_write32_byteenable;

  xsim_dma_burst_arbiter #(.NUM_CLIENTS(N), .BEATS_W(BW)) dut (
    .CLK                    (CLK),
    .RST                    (RST),
    .rd_req_valid           (rd_req_valid),
    .rd_req_ready           (rd_req_ready),
    .rd_req_handle          (rd_req_handle),
    .rd_req_addr            (rd_req_addr),
    .rd_req_beats           (rd_req_beats),
    .rd_data_valid          (rd_data_valid),
    .rd_data_ready          (rd_data_ready),
    .rd_data                (rd_data),
    .rd_data_last           (rd_data_last),
    .wr_valid               (wr_valid),
    .wr_ready               (wr_ready),
    .wr_handle              (wr_handle),
    .wr_addr                (wr_addr),
    .wr_data                (wr_data),
    .wr_byteenable          (wr_byteenable),
    .dma_rdy_readrequest    (dma_rdy_readrequest),
    .dma_en_readrequest     (dma_en_readrequest),
    .dma_readrequest_addr   (dma_readrequest_addr),
    .dma_readrequest_handle (dma_readrequest_handle),
    .dma_rdy_readresponse   (dma_rdy_readresponse),
    .dma_en_readresponse    (dma_en_readresponse),
    .dma_readresponse_data  (dma_readresponse_data),
    .dma_en_write32         (dma_en_write32),
    .dma_write32_addr       (dma_write32_addr),
    .dma_write32_handle     (dma_write32_handle),
    .dma_write32_data       (dma_write32_data),
    .dma_write32_byteenable (dma_write32_byteenable)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          client;
    logic [31:0] handle;
    logic [31:0] addr;
    logic [7:0]  beats;
    logic        toggle;
    logic [31:0] exp_last_addr;
  } burst_vec_t;

  typedef struct {
    logic [3:0] wv;
    logic [3:0] exp_ready;
  } wr_vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Client-side request shadows, driven onto the DUT at each negedge.
  logic [N-1:0]  pend;
  logic [31:0]   p_handle [N];
  logic [31:0]   p_addr   [N];
  logic [BW-1:0] p_beats  [N];
  logic [N-1:0]  wv;
  logic          rst_req;
  logic          toggle_mode;
  logic          tog;

  // Endpoint model and burst scoreboard.
  logic        ep_full;
  logic [31:0] ep_data;
  logic        act;
  int          own, tot, iss, ret, grant_cyc, grants_seen;
  logic [31:0] base, hnd, last_issue_addr;
  logic        grant_next_exp;
  int          exp_q[$];

  function automatic logic [31:0] wh(input int c); return 32'h1000_0000 + 32'(c); endfunction
  function automatic logic [31:0] wa(input int c); return 32'h2000_0000 + 32'(c * 16); endfunction
  function automatic logic [31:0] wd(input int c); return 32'hD00D_0000 + 32'(c * 32'h111); endfunction
  function automatic logic [3:0]  wb(input int c); return 4'(c + 1); endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // One clock: drive at negedge, sample 1 time unit later, update the models.
  task automatic step();
    logic        nfull;
    logic [31:0] ndata;
    int          gi;
    @(negedge CLK);
    RST                   = rst_req;
    dma_rdy_readrequest   = !ep_full;
    dma_rdy_readresponse  = ep_full;
    dma_readresponse_data = ep_data;
    rd_req_valid          = pend;
    rd_data_ready         = tog ? '1 : '0;
    wr_valid              = wv;
    for (int c = 0; c < int'(N); c++) begin
      rd_req_handle[32*c +: 32] = p_handle[c];
      rd_req_addr[32*c +: 32]   = p_addr[c];
      rd_req_beats[BW*c +: BW]  = p_beats[c];
      wr_handle[32*c +: 32]     = wh(c);
      wr_addr[32*c +: 32]       = wa(c);
      wr_data[32*c +: 32]       = wd(c);
      wr_byteenable[4*c +: 4]   = wb(c);
    end
    #1;
    nfull = ep_full;
    ndata = ep_data;
    if (rst_req) begin
      nfull = 1'b0;
      act   = 1'b0;
    end else begin
      if (grant_next_exp) begin
        chk("regrant_next_cycle", 32'(rd_req_ready != '0), 32'd1);
        grant_next_exp = 1'b0;
      end
      if (rd_req_ready != '0) begin
        chk("grant_no_overlap", 32'(act), 32'd0);
        gi = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        chk("grant_onehot", 32'(rd_req_ready), (gi >= 0) ? (32'd1 << gi) : 32'd0);
        own = (gi >= 0) ? gi : 0;
        act = 1'b1;
        tot = int'(p_beats[own]) + 1;
        base = p_addr[own];
        hnd = p_handle[own];
        iss = 0;
        ret = 0;
        grant_cyc = cyc;
        pend[own] = 1'b0;
        grants_seen++;
      end
      if (dma_en_readrequest) begin
        chk("issue_rdy", 32'(dma_rdy_readrequest), 32'd1);
        chk("issue_in_burst", 32'(act && iss < tot), 32'd1);
        if (act) begin
          if (iss == 0) chk("first_issue_latency", 32'(cyc - grant_cyc), 32'd1);
          chk("issue_addr", dma_readrequest_addr, base + 32'(4 * iss));
          chk("issue_handle", dma_readrequest_handle, hnd);
          last_issue_addr = dma_readrequest_addr;
          iss++;
        end
        nfull = 1'b1;
        ndata = dma_readrequest_addr ^ dma_readrequest_handle ^ 32'hA5A5_0000;
      end
      if (act && ep_full) begin
        chk("rsp_valid", 32'(rd_data_valid), 32'd1 << own);
        chk("rsp_data", rd_data, ep_data);
        chk("rsp_last", 32'(rd_data_last), 32'(ret == tot - 1));
        chk("rsp_consume", 32'(dma_en_readresponse), 32'(tog));
        if (dma_en_readresponse) begin
          nfull = 1'b0;
          ret++;
        end
        if (toggle_mode) tog = !tog;
        if (ret == tot) begin
          chk("issue_count", 32'(iss), 32'(tot));
          act = 1'b0;
          grant_next_exp = (pend != '0);
        end
      end else begin
        chk("rsp_idle", 32'({rd_data_valid, dma_en_readresponse, rd_data_last}), 32'd0);
      end
    end
    ep_full = nfull;
    ep_data = ndata;
    cyc++;
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    pend = '0;
    wv = '0;
    step();
    rst_req = 1'b0;
    exp_q.delete();
    grants_seen = 0;
    grant_next_exp = 1'b0;
    tog = 1'b1;
    toggle_mode = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_req_ready"}, 32'(rd_req_ready), 32'd0);
    chk({tag, "_rd_data_valid"}, 32'(rd_data_valid), 32'd0);
    chk({tag, "_rd_data_last"}, 32'(rd_data_last), 32'd0);
    chk({tag, "_en_rdreq"}, 32'(dma_en_readrequest), 32'd0);
    chk({tag, "_en_rdrsp"}, 32'(dma_en_readresponse), 32'd0);
    chk({tag, "_rdreq_addr"}, dma_readrequest_addr, 32'd0);
    chk({tag, "_rdreq_handle"}, dma_readrequest_handle, 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    chk({tag, "_en_write"}, 32'(dma_en_write32), 32'd0);
    chk({tag, "_wr_fields"}, dma_write32_addr | dma_write32_handle | dma_write32_data
                             | 32'(dma_write32_byteenable), 32'd0);
  endtask

  task automatic run_reads(input string name, input int budget);
    int n;
    n = 0;
    while ((act || pend != '0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeout(name);
  endtask

  burst_vec_t bv[3];
  wr_vec_t    wt[11];

  initial begin
    logic       prev_en;
    int         prev_c;
    logic       rearmed;

    bv[0] = '{client: 0, handle: 32'h0000_00A0, addr: 32'h0000_0100, beats: 8'd0,
              toggle: 1'b0, exp_last_addr: 32'h0000_0100};
    bv[1] = '{client: 2, handle: 32'h0000_00B2, addr: 32'h0000_0200, beats: 8'd3,
              toggle: 1'b1, exp_last_addr: 32'h0000_020C};
    bv[2] = '{client: 1, handle: 32'h0000_00C1, addr: 32'hFFFF_FFF8, beats: 8'd3,
              toggle: 1'b0, exp_last_addr: 32'h0000_0004};

    wt[0]  = '{wv: 4'b1111, exp_ready: 4'b0001};
    wt[1]  = '{wv: 4'b1111, exp_ready: 4'b0010};
    wt[2]  = '{wv: 4'b1111, exp_ready: 4'b0100};
    wt[3]  = '{wv: 4'b1111, exp_ready: 4'b1000};
    wt[4]  = '{wv: 4'b1111, exp_ready: 4'b0001};
    wt[5]  = '{wv: 4'b0000, exp_ready: 4'b0000};
    wt[6]  = '{wv: 4'b1010, exp_ready: 4'b0010};
    wt[7]  = '{wv: 4'b1010, exp_ready: 4'b1000};
    wt[8]  = '{wv: 4'b0101, exp_ready: 4'b0001};
    wt[9]  = '{wv: 4'b0100, exp_ready: 4'b0100};
    wt[10] = '{wv: 4'b1001, exp_ready: 4'b1000};

    RST = 1'b1;
    rd_req_valid = '0; rd_req_handle = '0; rd_req_addr = '0; rd_req_beats = '0;
    rd_data_ready = '0; wr_valid = '0; wr_handle = '0; wr_addr = '0; wr_data = '0;
    wr_byteenable = '0; dma_rdy_readrequest = 1'b0; dma_rdy_readresponse = 1'b0;
    dma_readresponse_data = '0;
    pend = '0; wv = '0; rst_req = 1'b1; tog = 1'b1; toggle_mode = 1'b0;
    ep_full = 1'b0; ep_data = '0; act = 1'b0; own = 0; tot = 0; iss = 0; ret = 0;
    grant_cyc = 0; grants_seen = 0; base = '0; hnd = '0; last_issue_addr = '0;
    grant_next_exp = 1'b0;
    for (int c = 0; c < int'(N); c++) begin
      p_handle[c] = '0; p_addr[c] = '0; p_beats[c] = '0;
    end

    do_reset();
    do_reset();
    step();
    check_all_zero("reset");

    // Single-client bursts from the table.
    for (int i = 0; i < 3; i++) begin
      p_handle[bv[i].client] = bv[i].handle;
      p_addr[bv[i].client]   = bv[i].addr;
      p_beats[bv[i].client]  = bv[i].beats;
      pend[bv[i].client]     = 1'b1;
      toggle_mode = bv[i].toggle;
      tog = 1'b1;
      exp_q.push_back(bv[i].client);
      run_reads($sformatf("burst%0d", i), 200);
      chk($sformatf("burst%0d_last_addr", i), last_issue_addr, bv[i].exp_last_addr);
      step();
    end

    // Clients 0,1,3 together from reset; client 0 re-requests after 1 is granted.
    do_reset();
    p_handle[0] = 32'h0000_0D00; p_addr[0] = 32'h0000_1000; p_beats[0] = 8'd1;
    p_handle[1] = 32'h0000_0D01; p_addr[1] = 32'h0000_2000; p_beats[1] = 8'd2;
    p_handle[3] = 32'h0000_0D03; p_addr[3] = 32'h0000_3000; p_beats[3] = 8'd0;
    pend = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(0);
    rearmed = 1'b0;
    for (int n = 0; n < 300 && (act || pend != '0 || exp_q.size() > 0); n++) begin
      step();
      if (grants_seen == 2 && !rearmed) begin
        p_addr[0]  = 32'h0000_1800;
        p_beats[0] = 8'd1;
        pend[0]    = 1'b1;
        rearmed    = 1'b1;
      end
    end
    if (act || pend != '0 || exp_q.size() > 0) timeout("multi_client");
    chk("multi_client_grants", 32'(grants_seen), 32'd4);
    chk("multi_client_last_addr", last_issue_addr, 32'h0000_1804);

    // Write rotation and selection from the table.
    do_reset();
    prev_en = 1'b0;
    prev_c  = 0;
    for (int i = 0; i < 11; i++) begin
      wv = wt[i].wv;
      step();
      chk($sformatf("wr_ready_%0d", i), 32'(wr_ready), 32'(wt[i].exp_ready));
      chk($sformatf("wr_en_%0d", i), 32'(dma_en_write32), 32'(prev_en));
      if (prev_en) begin
        chk($sformatf("wr_addr_%0d", i), dma_write32_addr, wa(prev_c));
        chk($sformatf("wr_handle_%0d", i), dma_write32_handle, wh(prev_c));
        chk($sformatf("wr_data_%0d", i), dma_write32_data, wd(prev_c));
        chk($sformatf("wr_be_%0d", i), 32'(dma_write32_byteenable), 32'(wb(prev_c)));
      end
      prev_en = (wt[i].exp_ready != 4'b0000);
      for (int c = 0; c < int'(N); c++) if (wt[i].exp_ready[c]) prev_c = c;
    end
    wv = '0;
    step();
    chk("wr_tail_en", 32'(dma_en_write32), 32'(prev_en));
    chk("wr_tail_data", dma_write32_data, wd(prev_c));

    // Reset in the middle of an 8-beat burst.
    do_reset();
    p_handle[2] = 32'h0000_0E02; p_addr[2] = 32'h0000_4000; p_beats[2] = 8'd7;
    pend[2] = 1'b1;
    exp_q.push_back(2);
    for (int n = 0; n < 100 && iss < 2; n++) step();
    if (iss < 2) timeout("midburst_reach");
    do_reset();
    step();
    check_all_zero("midburst");
    p_handle[0] = 32'h0000_0F00; p_addr[0] = 32'h0000_5000; p_beats[0] = 8'd1;
    p_handle[2] = 32'h0000_0F02; p_addr[2] = 32'h0000_6000; p_beats[2] = 8'd0;
    pend = 4'b0101;
    exp_q.push_back(0); exp_q.push_back(2);
    run_reads("post_reset", 200);
    chk("post_reset_grants", 32'(grants_seen), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
